// File: rtl/fcvt_pkg.sv
// Shared types and constants for the iterative float<->int32 converter.
package fcvt_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_ROUND,
    S_DONE
  } state_e;

  // Operand classes whose result is forced in ROUND instead of taken from the shifter
  typedef enum logic [2:0] {
    SP_NONE,
    SP_ZERO,
    SP_ZERO_NX,
    SP_ZERO_NV,
    SP_MAX_NV,
    SP_MIN_NV,
    SP_MIN
  } special_e;

  typedef struct packed {
    logic [31:0] res;
    logic [1:0]  flags;
  } conv_out_t;

  localparam logic [7:0]  BIAS           = 8'd127;
  localparam logic [7:0]  EXP_INT2F_BASE = 8'd158;
  localparam logic [7:0]  EXP_F2I_ALIGN  = BIAS + 8'd23;
  localparam logic [7:0]  EXP_S_OVF      = BIAS + 8'd31;
  localparam logic [7:0]  EXP_U_OVF      = BIAS + 8'd32;

  localparam logic [31:0] SAT_SMAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_SMIN = 32'h8000_0000;
  localparam logic [31:0] SAT_UMAX = 32'hFFFF_FFFF;

  localparam logic        CONV_F2I = 1'b0;
  localparam logic        CONV_I2F = 1'b1;

  localparam logic [1:0]  FLAG_NV = 2'b10;
  localparam logic [1:0]  FLAG_NX = 2'b01;

  function automatic conv_out_t special_out(input special_e sp, input logic sgn);
    conv_out_t o;
    o.res   = '0;
    o.flags = 2'b00;
    case (sp)
      SP_ZERO_NX: o.flags = FLAG_NX;
      SP_ZERO_NV: o.flags = FLAG_NV;
      SP_MAX_NV: begin
        o.res   = sgn ? SAT_SMAX : SAT_UMAX;
        o.flags = FLAG_NV;
      end
      SP_MIN_NV: begin
        o.res   = SAT_SMIN;
        o.flags = FLAG_NV;
      end
      SP_MIN:    o.res = SAT_SMIN;
      default:   ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/fcvt_lzc32.sv
// Combinational 32-bit leading-zero counter; an all-zero input reports 31.
module fcvt_lzc32 (
  input  logic [31:0] val_i,
  output logic [4:0]  cnt_o
);

  always_comb begin
    cnt_o = 5'd31;
    for (int unsigned i = 0; i < 32; i++) begin
      if (val_i[i]) cnt_o = 5'(31 - i);
    end
  end

endmodule

// File: rtl/fcvt_iter.sv
// Multi-cycle float<->int32 converter: RTZ for float->int, RNE for int->float,
// one bit of alignment/normalisation shift per cycle.
module fcvt_iter
  import fcvt_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] a_i,
  input  logic        op_signed_i,
  input  logic        conv_type_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic [1:0]  flags_o
);

  state_e      state_q, state_d;
  special_e    spec_q, spec_d;
  logic [31:0] work_q, work_d;
  logic        sticky_q, sticky_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        conv_q, conv_d;
  logic        sgn_q, sgn_d;
  logic        neg_q, neg_d;
  logic        left_q, left_d;
  logic [7:0]  exp_q, exp_d;
  logic [31:0] result_q, result_d;
  logic [1:0]  flags_q, flags_d;

  logic        accept;
  logic        i2f_neg;
  logic [31:0] i2f_mag;
  logic [4:0]  lzc_n;

  special_e    dec_spec;
  logic [31:0] dec_work;
  logic [4:0]  dec_cnt;
  logic        dec_left;
  logic        dec_neg;
  logic [7:0]  dec_exp;
  logic [7:0]  fexp;
  logic [22:0] ffrac;
  logic        fneg;

  logic        rnd_guard, rnd_sticky, rnd_up;
  logic [23:0] rnd_mant;
  logic [7:0]  rnd_exp;
  logic [31:0] f2i_res, i2f_res;
  conv_out_t   spec_res;

  assign accept  = valid_i & ready_o;
  assign i2f_neg = op_signed_i & a_i[31];
  assign i2f_mag = i2f_neg ? ('0 - a_i) : a_i;

  fcvt_lzc32 u_lzc (
    .val_i (i2f_mag),
    .cnt_o (lzc_n)
  );

  // Operand classification and shift setup, consumed only on the accept edge
  always_comb begin
    fexp     = a_i[30:23];
    ffrac    = a_i[22:0];
    fneg     = a_i[31];
    dec_spec = SP_NONE;
    dec_work = {8'b0, 1'b1, ffrac};
    dec_cnt  = '0;
    dec_left = 1'b0;
    dec_neg  = fneg;
    dec_exp  = '0;
    if (conv_type_i == CONV_F2I) begin
      if (fexp == 8'hFF) begin
        if (ffrac != '0)       dec_spec = SP_MAX_NV;
        else if (!fneg)        dec_spec = SP_MAX_NV;
        else if (op_signed_i)  dec_spec = SP_MIN_NV;
        else                   dec_spec = SP_ZERO_NV;
      end else if (fexp < BIAS) begin
        dec_spec = (fexp == '0 && ffrac == '0) ? SP_ZERO : SP_ZERO_NX;
      end else if (fneg && !op_signed_i) begin
        dec_spec = SP_ZERO_NV;
      end else if (op_signed_i && fexp >= EXP_S_OVF) begin
        if (!fneg)                                 dec_spec = SP_MAX_NV;
        else if (fexp == EXP_S_OVF && ffrac == '0) dec_spec = SP_MIN;
        else                                       dec_spec = SP_MIN_NV;
      end else if (!op_signed_i && fexp >= EXP_U_OVF) begin
        dec_spec = SP_MAX_NV;
      end else if (fexp <= EXP_F2I_ALIGN) begin
        dec_cnt = 5'(EXP_F2I_ALIGN - fexp);
      end else begin
        dec_left = 1'b1;
        dec_cnt  = 5'(fexp - EXP_F2I_ALIGN);
      end
    end else begin
      dec_neg  = i2f_neg;
      dec_work = i2f_mag;
      dec_left = 1'b1;
      if (a_i == '0) begin
        dec_spec = SP_ZERO;
      end else begin
        dec_cnt = lzc_n;
        dec_exp = EXP_INT2F_BASE - {3'b000, lzc_n};
      end
    end
  end

  always_comb begin
    rnd_guard  = work_q[7];
    rnd_sticky = |work_q[6:0];
    rnd_up     = rnd_guard & (rnd_sticky | work_q[8]);
    // A carry out of the 23-bit mantissa leaves its low bits zero, so only the exponent needs bumping
    rnd_mant   = {1'b0, work_q[30:8]} + {23'b0, rnd_up};
    rnd_exp    = rnd_mant[23] ? exp_q + 8'd1 : exp_q;
    i2f_res    = {neg_q, rnd_exp, rnd_mant[22:0]};
    f2i_res    = (sgn_q & neg_q) ? ('0 - work_q) : work_q;
    spec_res   = special_out(spec_q, sgn_q);
  end

  always_comb begin
    work_d   = work_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    conv_d   = conv_q;
    sgn_d    = sgn_q;
    neg_d    = neg_q;
    left_d   = left_q;
    exp_d    = exp_q;
    spec_d   = spec_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          work_d   = dec_work;
          sticky_d = 1'b0;
          cnt_d    = dec_cnt;
          conv_d   = conv_type_i;
          sgn_d    = op_signed_i;
          neg_d    = dec_neg;
          left_d   = dec_left;
          exp_d    = dec_exp;
          spec_d   = dec_spec;
        end
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 5'd1;
          if (left_q) begin
            work_d = {work_q[30:0], 1'b0};
          end else begin
            work_d   = {1'b0, work_q[31:1]};
            sticky_d = sticky_q | work_q[0];
          end
        end
      end
      S_ROUND: begin
        if (spec_q != SP_NONE) begin
          result_d = spec_res.res;
          flags_d  = spec_res.flags;
        end else if (conv_q == CONV_F2I) begin
          result_d = f2i_res;
          flags_d  = {1'b0, sticky_q};
        end else begin
          result_d = i2f_res;
          flags_d  = {1'b0, rnd_guard | rnd_sticky};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      work_q   <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      conv_q   <= 1'b0;
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
      left_q   <= 1'b0;
      exp_q    <= '0;
      spec_q   <= SP_NONE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      work_q   <= work_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      conv_q   <= conv_d;
      sgn_q    <= sgn_d;
      neg_q    <= neg_d;
      left_q   <= left_d;
      exp_q    <= exp_d;
      spec_q   <= spec_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == '0) state_d = S_ROUND;
      S_ROUND: state_d = S_DONE;
      S_DONE:  if (ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_q == S_IDLE) & ~rst_i;
    valid_o = (state_q == S_DONE);
  end

  assign result_o = result_q;
  assign flags_o  = flags_q;

endmodule

// File: tb/tb_fcvt_iter.sv
// Scoreboard bench for fcvt_iter: directed conversions, backpressure and mid-operation reset.
module tb_fcvt_iter;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] a_i = '0;
  logic        op_signed_i = 1'b0;
  logic        conv_type_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] result_o;
  logic [1:0]  flags_o;

  fcvt_iter dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .a_i         (a_i),
    .op_signed_i (op_signed_i),
    .conv_type_i (conv_type_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .result_o    (result_o),
    .flags_o     (flags_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  flg;
    int          lat;
    int          id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   accept_cyc = 0;
  int   valid_cyc = 0;
  bit   seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: latency is measured from the accept edge to the edge that raises valid_o
  always @(negedge clk) begin
    if (valid_i && ready_o) accept_cyc = cyc + 1;
    if (rst_i) begin
      seen = 1'b0;
    end else begin
      if (valid_o && !seen) begin
        seen = 1'b1;
        valid_cyc = cyc;
      end
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got %h expected none", result_o);
        end else begin
          mon_e = sb.pop_front();
          check($sformatf("vec%0d_result", mon_e.id), result_o, mon_e.res);
          check($sformatf("vec%0d_flags", mon_e.id), {30'b0, flags_o}, {30'b0, mon_e.flg});
          check($sformatf("vec%0d_latency", mon_e.id), 32'(valid_cyc - accept_cyc), 32'(mon_e.lat));
        end
        seen = 1'b0;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic sgn, input logic conv,
                       input logic [31:0] er, input logic [1:0] ef, input int lat, input int id);
    bit ok;
    sb.push_back('{er, ef, lat, id});
    a_i = a;
    op_signed_i = sgn;
    conv_type_i = conv;
    valid_i = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout($sformatf("vec%0d_accept", id));
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic drain(input int id);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      timeout($sformatf("vec%0d_done", id));
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [31:0] a, input logic sgn, input logic conv,
                     input logic [31:0] er, input logic [1:0] ef, input int lat, input int id);
    issue(a, sgn, conv, er, ef, lat, id);
    drain(id);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    #1;
    check("rst_ready", {31'b0, ready_o}, 32'd0);
    check("rst_valid", {31'b0, valid_o}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    #1;
    check("idle_ready", {31'b0, ready_o}, 32'd1);
    check("idle_valid", {31'b0, valid_o}, 32'd0);
    check("idle_result", result_o, 32'h0);
    check("idle_flags", {30'b0, flags_o}, 32'd0);
    @(posedge clk);
    #1;

    // float->int (conv=0)
    run(32'h4048F5C3, 1'b0, 1'b0, 32'h0000_0003, 2'b01, 24, 1);
    run(32'hC048F5C3, 1'b1, 1'b0, 32'hFFFF_FFFD, 2'b01, 24, 2);
    run(32'h7F800000, 1'b0, 1'b0, 32'hFFFF_FFFF, 2'b10,  2, 3);
    run(32'hBF800000, 1'b0, 1'b0, 32'h0000_0000, 2'b10,  2, 4);
    run(32'h3E800000, 1'b0, 1'b0, 32'h0000_0000, 2'b01,  2, 5);
    run(32'hCF000000, 1'b1, 1'b0, 32'h8000_0000, 2'b00,  2, 6);
    run(32'h4F000000, 1'b1, 1'b0, 32'h7FFF_FFFF, 2'b10,  2, 7);
    run(32'h4F000000, 1'b0, 1'b0, 32'h8000_0000, 2'b00, 10, 8);
    run(32'h3F800000, 1'b1, 1'b0, 32'h0000_0001, 2'b00, 25, 9);
    run(32'h7FC00000, 1'b1, 1'b0, 32'h7FFF_FFFF, 2'b10,  2, 10);
    run(32'h00000000, 1'b1, 1'b0, 32'h0000_0000, 2'b00,  2, 11);
    // int->float (conv=1)
    run(32'h00000064, 1'b0, 1'b1, 32'h42C8_0000, 2'b00, 27, 12);
    run(32'hFFFFFF9C, 1'b1, 1'b1, 32'hC2C8_0000, 2'b00, 27, 13);
    run(32'hFFFFFF9C, 1'b0, 1'b1, 32'h4F80_0000, 2'b01,  2, 14);
    run(32'h80000000, 1'b1, 1'b1, 32'hCF00_0000, 2'b00,  2, 15);
    run(32'h00000000, 1'b1, 1'b1, 32'h0000_0000, 2'b00,  2, 16);
    run(32'h00000001, 1'b0, 1'b1, 32'h3F80_0000, 2'b00, 33, 17);

    // Backpressure with a second request held on valid_i while busy
    ready_i = 1'b0;
    issue(32'h4048F5C3, 1'b0, 1'b0, 32'h0000_0003, 2'b01, 24, 20);
    a_i = 32'h00000064;
    op_signed_i = 1'b1;
    conv_type_i = 1'b1;
    valid_i = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (valid_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("bp_valid");
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_valid", {31'b0, valid_o}, 32'd1);
      check("bp_hold_ready", {31'b0, ready_o}, 32'd0);
      check("bp_hold_result", result_o, 32'h0000_0003);
      check("bp_hold_flags", {30'b0, flags_o}, 32'd1);
      @(negedge clk);
    end
    sb.push_back('{32'h42C8_0000, 2'b00, 27, 21});
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    @(negedge clk);
    check("done_exit_ready", {31'b0, ready_o}, 32'd0);
    ok = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("bp_second_accept");
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    drain(21);

    // Reset during SHIFT drops the operation
    a_i = 32'h00000001;
    op_signed_i = 1'b0;
    conv_type_i = 1'b1;
    valid_i = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_i = 1'b1;
    #1;
    check("midrst_valid", {31'b0, valid_o}, 32'd0);
    check("midrst_ready", {31'b0, ready_o}, 32'd0);
    check("midrst_result", result_o, 32'h0);
    check("midrst_flags", {30'b0, flags_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    #1;
    check("postrst_ready", {31'b0, ready_o}, 32'd1);
    repeat (40) @(posedge clk);
    #1;
    check("postrst_no_valid", {31'b0, valid_o}, 32'd0);
    run(32'hC048F5C3, 1'b1, 1'b0, 32'hFFFF_FFFD, 2'b01, 24, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
